// File: rtl/posit_sched_pkg.sv
// posit_sched_pkg: shared types and default sizes for the posit dispatch scheduler
package posit_sched_pkg;
  typedef logic [1:0] posit_op_t;
  localparam int POSIT_W = 32;
  localparam int N_UNITS_DEF = 4;
  localparam int ROB_DEPTH_DEF = 8;
endpackage

// File: rtl/posit_sched_rob.sv
// posit_sched_rob: reorder buffer returning unit results in arrival order
module posit_sched_rob
  import posit_sched_pkg::*;
#(
  parameter int N_UNITS = N_UNITS_DEF,
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int TAG_W = $clog2(ROB_DEPTH),
  parameter int CNT_W = $clog2(ROB_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alloc,
  input  logic [N_UNITS-1:0]                wr_en,
  input  logic [N_UNITS-1:0][TAG_W-1:0]     wr_tag,
  input  logic [N_UNITS-1:0][POSIT_W-1:0]   wr_data,
  input  logic                              res_ready,
  output logic                              res_valid,
  output logic [POSIT_W-1:0]                res_data,
  output logic [TAG_W-1:0]                  wr_ptr,
  output logic [CNT_W-1:0]                  count
);
  logic [ROB_DEPTH-1:0] valid;
  logic [POSIT_W-1:0]   data [ROB_DEPTH];
  logic [TAG_W-1:0]     rd_ptr;
  logic                 retire;
  assign res_valid = valid[rd_ptr];
  assign res_data  = data[rd_ptr];
  assign retire    = res_valid & res_ready;
  // A write never targets the head slot while it is valid, so clear and write cannot collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) data[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (retire) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + TAG_W'(1);
      end
      for (int k = 0; k < N_UNITS; k++) begin
        if (wr_en[k]) begin
          valid[wr_tag[k]] <= 1'b1;
          data[wr_tag[k]]  <= wr_data[k];
        end
      end
      if (alloc) wr_ptr <= wr_ptr + TAG_W'(1);
      count <= count + CNT_W'(alloc) - CNT_W'(retire);
    end
  end
endmodule

// File: rtl/posit_dispatch_sched.sv
// posit_dispatch_sched: round-robin dispatch of posit operand pairs with in-order return.
// Defining POSIT_SCHED_PERF_EN adds issue and stall performance counters.
module posit_dispatch_sched
  import posit_sched_pkg::*;
#(
  parameter int N_UNITS = N_UNITS_DEF,
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int TAG_W = $clog2(ROB_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [POSIT_W-1:0]          in_a_i,
  input  logic [POSIT_W-1:0]          in_b_i,
  input  posit_op_t                   in_op_i,
  output logic [N_UNITS-1:0]          unit_start_o,
  output logic [2*N_UNITS-1:0]        unit_op_o,
  output logic [POSIT_W*N_UNITS-1:0]  unit_a_o,
  output logic [POSIT_W*N_UNITS-1:0]  unit_b_o,
  input  logic [N_UNITS-1:0]          unit_done_i,
  input  logic [POSIT_W*N_UNITS-1:0]  unit_out_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [POSIT_W-1:0]          res_data_o,
  output logic                        idle_o
`ifdef POSIT_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_issued_o,
  output logic [31:0]                 perf_stall_o
`endif
);
  localparam int UW = N_UNITS > 1 ? $clog2(N_UNITS) : 1;
  localparam int CNT_W = $clog2(ROB_DEPTH + 1);
  logic [N_UNITS-1:0]                busy, start_q, wr_en;
  logic [N_UNITS-1:0][TAG_W-1:0]     tag;
  posit_op_t [N_UNITS-1:0]           op_q;
  logic [N_UNITS-1:0][POSIT_W-1:0]   a_q, b_q;
  logic [UW-1:0]                     rr_ptr, sel, j;
  logic [TAG_W-1:0]                  wr_ptr;
  logic [CNT_W-1:0]                  count;
  logic                              issue;
  assign in_ready_o   = (count != CNT_W'(ROB_DEPTH)) && !(&busy);
  assign issue        = in_valid_i & in_ready_o;
  assign idle_o       = count == '0;
  assign wr_en        = unit_done_i & busy;
  assign unit_start_o = start_q;
  assign unit_op_o    = op_q;
  assign unit_a_o     = a_q;
  assign unit_b_o     = b_q;
  // Scan backwards so the last overwrite is the first free unit at or after rr_ptr
  always_comb begin
    sel = '0;
    j   = '0;
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      j = UW'((int'(rr_ptr) + i) % N_UNITS);
      if (!busy[j]) sel = j;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy    <= '0;
      start_q <= '0;
      tag     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rr_ptr  <= '0;
    end else begin
      start_q <= '0;
      for (int k = 0; k < N_UNITS; k++) begin
        if (wr_en[k]) begin
          busy[k] <= 1'b0;
          op_q[k] <= '0;
          a_q[k]  <= '0;
          b_q[k]  <= '0;
        end
      end
      if (issue) begin
        busy[sel]    <= 1'b1;
        start_q[sel] <= 1'b1;
        tag[sel]     <= wr_ptr;
        op_q[sel]    <= in_op_i;
        a_q[sel]     <= in_a_i;
        b_q[sel]     <= in_b_i;
        rr_ptr       <= (sel == UW'(N_UNITS - 1)) ? '0 : sel + UW'(1);
      end
    end
  end
  posit_sched_rob #(
    .N_UNITS(N_UNITS), .ROB_DEPTH(ROB_DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) u_rob (
    .clk(clk_i),
    .rst_n(rst_ni),
    .alloc(issue),
    .wr_en(wr_en),
    .wr_tag(tag),
    .wr_data(unit_out_i),
    .res_ready(res_ready_i),
    .res_valid(res_valid_o),
    .res_data(res_data_o),
    .wr_ptr(wr_ptr),
    .count(count)
  );
`ifdef POSIT_SCHED_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      perf_issued_o <= perf_issued_o + 32'(issue);
      perf_stall_o  <= perf_stall_o + 32'(in_valid_i & ~in_ready_o);
    end
  end
`endif
endmodule

// File: tb/tb_posit_dispatch_sched.sv
// tb_posit_dispatch_sched: directed and random checks against an arrival-order reference model
module tb_posit_dispatch_sched;
  localparam int N = 4;
  localparam int D = 8;
  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [31:0]     in_a_i = '0, in_b_i = '0;
  logic [1:0]      in_op_i = '0;
  logic [N-1:0]    unit_start_o;
  logic [2*N-1:0]  unit_op_o;
  logic [32*N-1:0] unit_a_o, unit_b_o;
  logic [N-1:0]    unit_done_i = '0;
  logic [32*N-1:0] unit_out_i = '0;
  logic            res_valid_o;
  logic            res_ready_i = 1'b0;
  logic [31:0]     res_data_o;
  logic            idle_o;

  posit_dispatch_sched dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_op_i(in_op_i),
    .unit_start_o(unit_start_o), .unit_op_o(unit_op_o),
    .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
    .unit_done_i(unit_done_i), .unit_out_i(unit_out_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  // Reference model: arrival sequence numbers, per-unit job, and finished results keyed by sequence
  bit          m_busy [N];
  int          m_seq  [N];
  logic [31:0] m_a [N], m_b [N];
  logic [1:0]  m_op [N];
  logic [N-1:0] m_start;
  int          m_rr, next_seq, head_seq;
  logic [31:0] results [int];
  int          n_cmp = 0, n_err = 0;

  function automatic void m_reset();
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 0; m_seq[k] = 0; m_a[k] = '0; m_b[k] = '0; m_op[k] = '0;
    end
    m_start = '0; m_rr = 0; next_seq = 0; head_seq = 0;
    results.delete();
  endfunction

  function automatic bit m_ready();
    bit f = 0;
    for (int k = 0; k < N; k++) if (!m_busy[k]) f = 1;
    return (next_seq - head_seq < D) && f;
  endfunction

  function automatic bit m_valid();
    return results.exists(head_seq);
  endfunction

  function automatic logic [N-1:0] m_busy_mask();
    logic [N-1:0] m = '0;
    for (int k = 0; k < N; k++) m[k] = m_busy[k];
    return m;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0]    es;
    logic [32*N-1:0] ea, eb;
    logic [2*N-1:0]  eo;
    for (int k = 0; k < N; k++) begin
      es[k] = m_start[k];
      ea[k*32 +: 32] = m_busy[k] ? m_a[k] : 32'h0;
      eb[k*32 +: 32] = m_busy[k] ? m_b[k] : 32'h0;
      eo[k*2 +: 2]   = m_busy[k] ? m_op[k] : 2'h0;
    end
    check("in_ready", 128'(in_ready_o), 128'(m_ready()));
    check("idle", 128'(idle_o), 128'(next_seq == head_seq));
    check("res_valid", 128'(res_valid_o), 128'(m_valid()));
    if (m_valid()) check("res_data", 128'(res_data_o), 128'(results[head_seq]));
    check("unit_start", 128'(unit_start_o), 128'(es));
    check("unit_a", 128'(unit_a_o), 128'(ea));
    check("unit_b", 128'(unit_b_o), 128'(eb));
    check("unit_op", 128'(unit_op_o), 128'(eo));
  endtask

  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [N-1:0] dn, input logic [32*N-1:0] outs, input bit rdy);
    bit iss, ret;
    int pick;
    in_valid_i = v; in_a_i = a; in_b_i = b; in_op_i = op;
    unit_done_i = dn; unit_out_i = outs; res_ready_i = rdy;
    iss = v && m_ready();
    ret = rdy && m_valid();
    pick = -1;
    for (int i = 0; i < N; i++) if (pick < 0 && !m_busy[(m_rr + i) % N]) pick = (m_rr + i) % N;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (dn[k] && m_busy[k]) begin
        results[m_seq[k]] = outs[k*32 +: 32];
        m_busy[k] = 0; m_a[k] = '0; m_b[k] = '0; m_op[k] = '0;
      end
    end
    m_start = '0;
    if (iss) begin
      m_busy[pick] = 1; m_seq[pick] = next_seq; next_seq++;
      m_a[pick] = a; m_b[pick] = b; m_op[pick] = op;
      m_start[pick] = 1'b1;
      m_rr = (pick + 1) % N;
    end
    if (ret) begin
      results.delete(head_seq);
      head_seq++;
    end
    #1;
    check_all();
    in_valid_i = 0; unit_done_i = '0; res_ready_i = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0; in_valid_i = 0; unit_done_i = '0; res_ready_i = 0;
    #2;
    m_reset();
    check("rst_ready", 128'(in_ready_o), 128'(1));
    check("rst_idle", 128'(idle_o), 128'(1));
    check("rst_start", 128'(unit_start_o), 128'(0));
    check("rst_res_valid", 128'(res_valid_o), 128'(0));
    check("rst_res_data", 128'(res_data_o), 128'(0));
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [32*N-1:0] rnd_outs();
    logic [32*N-1:0] o;
    for (int k = 0; k < N; k++) o[k*32 +: 32] = $urandom;
    return o;
  endfunction

  initial begin
    bit reached;
    do_reset();
    // Round-robin issue, units never done
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h40000000, 32'h40000000, 2'd0, '0, '0, 0);
      check("rr_start", 128'(unit_start_o), 128'(4'b0001 << i));
    end
    check("rr_full_ready", 128'(in_ready_o), 128'(0));
    cycle(1, 32'h1, 32'h2, 2'd1, '0, '0, 0);
    check("rr_no_start", 128'(unit_start_o), 128'(0));
    // Out-of-order completion: units 3,1,0,2 finish
    cycle(0, '0, '0, 0, 4'b1000, {32'h11, 96'h0}, 0);
    check("ooo_head_wait", 128'(res_valid_o), 128'(0));
    cycle(0, '0, '0, 0, 4'b0010, {64'h0, 32'h22, 32'h0}, 0);
    cycle(0, '0, '0, 0, 4'b0001, {96'h0, 32'h33}, 0);
    check("ooo_first", 128'(res_data_o), 128'(32'h33));
    cycle(0, '0, '0, 0, 4'b0100, {32'h0, 32'h44, 64'h0}, 1);
    check("ooo_second", 128'(res_data_o), 128'(32'h22));
    cycle(0, '0, '0, 0, '0, '0, 1);
    check("ooo_third", 128'(res_data_o), 128'(32'h44));
    cycle(0, '0, '0, 0, '0, '0, 1);
    check("ooo_fourth", 128'(res_data_o), 128'(32'h11));
    cycle(0, '0, '0, 0, '0, '0, 1);
    check("ooo_drained", 128'(idle_o), 128'(1));
    // ROB full: fill all 8 entries with finished results, nothing retired
    reached = 0;
    for (int c = 0; c < 40 && !reached; c++) begin
      cycle(next_seq - head_seq < D, $urandom, $urandom, 2'($urandom), m_busy_mask(), rnd_outs(), 0);
      reached = (next_seq - head_seq == D) && (m_busy_mask() == '0);
    end
    check("rob_fill_reached", 128'(reached), 128'(1));
    check("rob_full_ready", 128'(in_ready_o), 128'(0));
    cycle(1, 32'h5, 32'h6, 2'd2, '0, '0, 0);
    check("rob_full_hold", 128'(in_ready_o), 128'(0));
    cycle(0, '0, '0, 0, '0, '0, 1);
    check("rob_retire_ready", 128'(in_ready_o), 128'(1));
    for (int c = 0; c < 20 && next_seq != head_seq; c++) cycle(0, '0, '0, 0, '0, '0, 1);
    // Spurious done on an idle unit
    cycle(0, '0, '0, 0, 4'b0100, rnd_outs(), 0);
    check("spur_res_valid", 128'(res_valid_o), 128'(0));
    check("spur_idle", 128'(idle_o), 128'(1));
    // Reset mid-flight
    for (int i = 0; i < 3; i++) cycle(1, $urandom, $urandom, 2'($urandom), '0, '0, 0);
    check("mid_busy", 128'(idle_o), 128'(0));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, '0, 0, 4'b0111, rnd_outs(), 1);
      check("mid_res_valid", 128'(res_valid_o), 128'(0));
    end
    check("mid_idle", 128'(idle_o), 128'(1));
    // Random traffic
    for (int c = 0; c < 600; c++)
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom), 4'($urandom), rnd_outs(),
            $urandom_range(0, 9) < 7);
    for (int c = 0; c < 100 && next_seq != head_seq; c++) cycle(0, '0, '0, 0, m_busy_mask(), rnd_outs(), 1);
    check("final_idle", 128'(idle_o), 128'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/posit_dispatch_sched.md
# posit_dispatch_sched

Issue scheduler that shares a pool of `posit_unit` instances between a single stream of posit operand pairs. It dispatches each pair to a free unit in round-robin order and tags the pair with its arrival order. A reorder buffer then returns results in that arrival order, regardless of per-unit latency. It sits between the SIMD coprocessor's operand memories and the posit units, and replaces hard-wired lane-to-unit binding.

## Interface
Parameters:
- `N_UNITS`, default 4: number of attached posit units; must be ≥1.
- `ROB_DEPTH`, default 8: reorder buffer entries; must be a power of two and ≥ `N_UNITS`.
- `TAG_W`, default `$clog2(ROB_DEPTH)`: tag width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `in_valid_i`, in, 1: operand pair valid.
- `in_ready_o`, out, 1: pair accepted when valid and ready are both high.
- `in_a_i`, in, 32: operand A.
- `in_b_i`, in, 32: operand B.
- `in_op_i`, in, 2: op code, passed to the unit unchanged.
- `unit_start_o`, out, N_UNITS: one-cycle start pulse per unit.
- `unit_op_o`, out, 2*N_UNITS: per-unit op code; unit k uses bits [2k+1:2k].
- `unit_a_o`, out, 32*N_UNITS: per-unit operand A.
- `unit_b_o`, out, 32*N_UNITS: per-unit operand B.
- `unit_done_i`, in, N_UNITS: per-unit done pulse.
- `unit_out_i`, in, 32*N_UNITS: per-unit result, valid while its done pulse is high.
- `res_valid_o`, out, 1: in-order result available.
- `res_ready_i`, in, 1: result consumer ready.
- `res_data_o`, out, 32: result data.
- `idle_o`, out, 1: no pair in flight and ROB empty.

## Operation
- State per unit: `busy[k]`, `tag[k]`, and registered operands and op. ROB state: `valid[ROB_DEPTH]`, `data[ROB_DEPTH]`, `wr_ptr`, `rd_ptr`, `count` (0..ROB_DEPTH). Round-robin pointer: `rr_ptr`.
- **`in_ready_o`**: high when `count < ROB_DEPTH` and at least one unit is not busy. It is derived from registers only, with no combinational path from any input.
- **Issue** on an input handshake:
  - Unit selection: k = first non-busy unit at or after `rr_ptr`, searching with wrap.
  - Unit k registers: operands and op; `tag[k] <= wr_ptr`; `busy[k] <= 1`.
  - Next cycle: `unit_start_o[k]` is high for exactly one cycle.
  - Pointers: `rr_ptr <= (k+1) mod N_UNITS`; `wr_ptr` increments, wrapping at ROB_DEPTH; `count` increments.
- **Operand hold**: `unit_a_o`, `unit_b_o` and `unit_op_o` hold until that unit's done. Idle units drive 0.
- **Completion**:
  - `unit_done_i[k]` with `busy[k]` set: write `unit_out_i[k]` to `data[tag[k]]`, set `valid[tag[k]]`, clear `busy[k]`.
  - Done pulses on several units in the same cycle are all accepted.
  - A done on a non-busy unit is ignored.
- **Retire**: `res_valid_o = valid[rd_ptr]` and `res_data_o = data[rd_ptr]`, both from registers. On a result handshake: clear `valid[rd_ptr]`, increment `rd_ptr`, decrement `count`.
- **Simultaneous issue and retire**: `count` is unchanged.
- **Same-cycle done and issue**: a unit freed by a done is not issuable in that same cycle. It becomes issuable in the next cycle.
- **Output stability**: `res_data_o` stays stable while `res_valid_o` is high and `res_ready_i` is low.
- **`idle_o`**: `count == 0`.
- **Reset mid-operation**: all in-flight work is discarded. Done pulses arriving after reset are ignored, because no unit is busy.

## Timing
- Reset values:
  - `unit_start_o`, `unit_op_o`, `unit_a_o`, `unit_b_o`, `res_valid_o`, `res_data_o`: 0.
  - `in_ready_o` and `idle_o`: 1.
  - Pointers and `count`: 0.
- Input handshake at edge E: `unit_start_o` is high in cycle E+1.
- Done in cycle D, with the tag at ROB head: `res_valid_o` is high in cycle D+1.
- Sustained throughput: one issue per cycle while units are free and the ROB has space.
- ROB full: `in_ready_o` stays low until a retire occurs.
- All units busy: `in_ready_o` stays low until a done occurs.

## Configuration
- `POSIT_SCHED_PERF_EN` defined: adds two outputs.
  - `perf_issued_o` [31:0]: counts input handshakes.
  - `perf_stall_o` [31:0]: counts cycles with `in_valid_i` high and `in_ready_o` low.
  - Both reset to 0 and wrap at 2^32.
- `POSIT_SCHED_PERF_EN` undefined: these ports and their counters do not exist.

## Structure
- Package `posit_sched_pkg`:
  - `posit_op_t`: 2-bit op code.
  - `POSIT_W = 32`.
  - Default `N_UNITS` and `ROB_DEPTH` constants.
- Sub-module `posit_sched_rob`: reorder buffer (entries, valid bits, read/write pointers, `count`, retire handshake).
- Top level: unit busy/tag bookkeeping and the round-robin picker.

## Test plan
- **Reset**: `rst_ni` low, then release → `in_ready_o=1`, `idle_o=1`, all `unit_start_o=0`.
- **Round-robin issue**: 4 pairs on back-to-back cycles (A=0x40000000, B=0x40000000, op=0), units never done → starts on units 0, 1, 2, 3 in successive cycles; `in_ready_o=0` after the 4th.
- **Out-of-order completion**:
  - Setup: units 0–3 hold tags 0–3.
  - Stimulus: done in unit order 3, 1, 0, 2 with outputs 0x11, 0x22, 0x33, 0x44.
  - Required: `res_data_o` sequence 0x33, 0x22, 0x44, 0x11.
- **ROB full**:
  - Setup: ROB_DEPTH=8; 8 results pending with `res_ready_i=0`.
  - Required: `in_ready_o=0`.
  - Stimulus: one retire.
  - Required: `in_ready_o=1` the next cycle.
- **Spurious done**: pulse `unit_done_i[2]` while unit 2 is idle → no ROB change, `res_valid_o` stays 0.
- **Reset mid-flight**: 3 pairs in flight, assert reset, then return done pulses → no result ever becomes valid; `idle_o=1`.
